// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and BCD decoder for the display blocks.
package seg7_pkg;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Map one BCD digit to its segment pattern; non-BCD codes blank the digit.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tick_bcd_counter_if.sv
// Control and display bundle between tick generators, counter and display pins.
interface tick_bcd_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  tick;
  logic                  scan_tick;
  logic                  en;
  logic                  up;
  logic                  clr;
  logic [4*DIGITS-1:0]   value;
  logic                  wrap;
  logic [DIGITS-1:0]     led_en;
  logic [7:0]            led_seg;

  modport master (
    output tick, scan_tick, en, up, clr,
    input  value, wrap, led_en, led_seg
  );

  modport slave (
    input  tick, scan_tick, en, up, clr,
    output value, wrap, led_en, led_seg
  );
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit (0..9) with wrap-around increment/decrement and carry/borrow out.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       co
);
  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: clear wins, then inc, then dec.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      q_d = (q_q >= 4'd9) ? 4'd0 : q_q + 4'd1;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 4'd0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign co = (inc & (q_q >= 4'd9)) | (dec & (q_q == 4'd0));
endmodule

// File: rtl/tick_bcd_counter.sv
// Multi-digit BCD up/down tick counter with multiplexed 7-segment output.
module tick_bcd_counter
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter bit          SEG_BLANK = 1'b1
) (
  input logic               clk,
  input logic               rst,
  tick_bcd_counter_if.slave bus
);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * DIGITS;

  logic [DIGITS:0]   inc_c;
  logic [DIGITS:0]   dec_c;
  logic [DIGITS-1:0] co_c;
  logic [VAL_W-1:0]  value_c;

  logic              wrap_q;
  logic              wrap_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [DIGITS-1:0] led_en_q;
  logic [DIGITS-1:0] led_en_d;
  logic [7:0]        led_seg_q;
  logic [7:0]        led_seg_d;

  logic [DIGITS-1:0] lz_c;
  logic [3:0]        digit_c;
  logic              blank_c;

  // clr masks counting so a clear never produces a wrap.
  assign inc_c[0] = bus.tick & bus.en & bus.up  & ~bus.clr;
  assign dec_c[0] = bus.tick & bus.en & ~bus.up & ~bus.clr;

  // Digit chain: each digit steps only when all lower digits carry/borrow.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk (clk),
      .rst (rst),
      .clr (bus.clr),
      .inc (inc_c[i]),
      .dec (dec_c[i]),
      .q   (value_c[4*i +: 4]),
      .co  (co_c[i])
    );
    assign inc_c[i+1] = inc_c[i] & co_c[i];
    assign dec_c[i+1] = dec_c[i] & co_c[i];
  end

  // Carry out of the top digit is a full rollover in either direction.
  assign wrap_d = inc_c[DIGITS] | dec_c[DIGITS];

  // Scan index advance with wrap at the last digit.
  always_comb begin
    idx_d = idx_q;
    if (bus.scan_tick) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Selected digit, leading-zero detection and next display outputs.
  always_comb begin
    lz_c           = '0;
    digit_c        = 4'd0;
    blank_c        = 1'b0;
    lz_c[DIGITS-1] = (value_c[VAL_W-1 -: 4] == 4'd0);
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      lz_c[i] = lz_c[i+1] & (value_c[4*i +: 4] == 4'd0);
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (IDX_W'(i) == idx_q) begin
        digit_c = value_c[4*i +: 4];
        blank_c = SEG_BLANK && (i != 0) && lz_c[i];
      end
    end
    led_en_d  = ~(DIGITS'(1) << idx_q);
    led_seg_d = blank_c ? SEG_OFF : bcd_to_seg(digit_c);
  end

  // Wrap pulse, scan index and display output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q    <= 1'b0;
      idx_q     <= '0;
      led_en_q  <= '1;
      led_seg_q <= SEG_OFF;
    end else begin
      wrap_q    <= wrap_d;
      idx_q     <= idx_d;
      led_en_q  <= led_en_d;
      led_seg_q <= led_seg_d;
    end
  end

  assign bus.value   = value_c;
  assign bus.wrap    = wrap_q;
  assign bus.led_en  = led_en_q;
  assign bus.led_seg = led_seg_q;
endmodule
